ltl_report_collector: RTL and testbench

Downstream consumer of an LTL monitor automaton cluster's report outputs. Each cycle the automaton runs, the block samples its report lines. Any non-zero report vector is tagged with the index of the symbol that produced it and queued in a small FIFO. The queue drains to the monitor aggregation logic over a valid/ready handshake, and overflow and drop statistics are kept alongside.

---
 rtl/ltl_mon_pkg.sv | 15 +
 rtl/ltl_rpt_fifo.sv | 79 +++++++
 rtl/ltl_report_collector.sv | 88 ++++++++
 tb/tb_ltl_report_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// rtl/ltl_mon_pkg.sv - shared defaults and record type for the LTL report collector
package ltl_mon_pkg;

  localparam int NUM_REPORTS_DEF = 4;
  localparam int IDX_W_DEF       = 32;
  localparam int DEPTH_DEF       = 8;
  localparam int DROP_W_DEF      = 16;

  // Record layout at the default widths; the modules build the same layout from their own parameters.
  typedef struct packed {
    logic [NUM_REPORTS_DEF-1:0] mask;
    logic [IDX_W_DEF-1:0]       index;
  } rpt_rec_t;

endpackage

// File: rtl/ltl_rpt_fifo.sv
// rtl/ltl_rpt_fifo.sv - synchronous FIFO with registered head and simultaneous push/pop
module ltl_rpt_fifo #(
  parameter  int W     = 36,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;
  assign dout  = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    // The head register tracks what the storage will hold at the new read pointer.
    if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = din;
    else                                   head_d = mem_q[rd_ptr_d];
    if (count_d == '0) head_d = '0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - tags non-zero automaton reports with symbol index and queues them
module ltl_report_collector
  import ltl_mon_pkg::*;
#(
  parameter  int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter  int IDX_W       = IDX_W_DEF,
  parameter  int DEPTH       = DEPTH_DEF,
  parameter  int DROP_W      = DROP_W_DEF,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_in,
  input  logic                   clear,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [NUM_REPORTS-1:0] rpt_mask,
  output logic [IDX_W-1:0]       rpt_index,
  output logic [LW-1:0]          fifo_level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  typedef struct packed {
    logic [NUM_REPORTS-1:0] mask;
    logic [IDX_W-1:0]       index;
  } rec_t;

  logic [IDX_W-1:0]  sym_idx_q, sym_idx_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              push_req, pop_req, drop, fifo_full, fifo_empty;
  rec_t              push_rec, head_rec;

  assign push_rec = '{mask: report_in, index: sym_idx_q};

  always_comb begin
    push_req     = run && (|report_in) && !clear;
    pop_req      = rpt_valid && rpt_ready && !clear;
    drop         = push_req && fifo_full && !pop_req;
    sym_idx_d    = run ? sym_idx_q + IDX_W'(1) : sym_idx_q;
    overflow_d   = overflow_q || drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_W'(1);
    // Clear wins over everything else that happens in the same cycle.
    if (clear) begin
      sym_idx_d    = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_idx_q    <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sym_idx_q    <= sym_idx_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  ltl_rpt_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (clear),
    .push  (push_req && !drop),
    .din   (push_rec),
    .pop   (pop_req),
    .dout  (head_rec),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign rpt_valid  = !fifo_empty;
  assign rpt_mask   = head_rec.mask;
  assign rpt_index  = head_rec.index;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ltl_report_collector.sv
// tb/tb_ltl_report_collector.sv - scoreboard bench for ltl_report_collector
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_i = 1'b0, clear_i = 1'b0, rpt_ready = 1'b0;
  logic [3:0]  report_i = '0;
  logic        rpt_valid, overflow;
  logic [3:0]  rpt_mask, fifo_level;
  logic [31:0] rpt_index;
  logic [15:0] drop_count;

  logic        run_w = 1'b0;
  logic [3:0]  report_w = '0;
  logic        valid_w, overflow_w;
  logic [3:0]  mask_w, index_w, level_w;
  logic [15:0] drop_w;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] index;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_idx = 0;
  int          m_drops = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ltl_report_collector dut (
    .clk(clk), .reset(reset), .run(run_i), .report_in(report_i), .clear(clear_i),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_mask(rpt_mask), .rpt_index(rpt_index),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  ltl_report_collector #(.IDX_W(4)) dut_w (
    .clk(clk), .reset(reset), .run(run_w), .report_in(report_w), .clear(1'b0),
    .rpt_valid(valid_w), .rpt_ready(1'b0), .rpt_mask(mask_w), .rpt_index(index_w),
    .fifo_level(level_w), .overflow(overflow_w), .drop_count(drop_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (reset && !clear_i && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_record: got mask %0h index %0d, expected none", rpt_mask, rpt_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_mask", 64'(rpt_mask), 64'(e.mask));
        check("pop_index", 64'(rpt_index), 64'(e.index));
      end
    end
  end

  task automatic tick(input logic r, input logic [3:0] rep, input logic clr);
    run_i = r; report_i = rep; clear_i = clr;
    @(negedge clk); #1;
    if (clr) begin
      exp_q.delete(); m_idx = 0; m_drops = 0;
    end else if (r) begin
      if (rep != 4'b0) begin
        if (exp_q.size() < 8) exp_q.push_back('{mask: rep, index: m_idx});
        else m_drops++;
      end
      m_idx++;
    end
    @(posedge clk); #1;
    run_i = 1'b0; report_i = '0; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; rpt_ready = 1'b0;
    exp_q.delete(); m_idx = 0; m_drops = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_valid", 64'(rpt_valid), 64'd0);
    check("reset_mask", 64'(rpt_mask), 64'd0);
    check("reset_index", 64'(rpt_index), 64'd0);
    check("reset_level", 64'(fifo_level), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_drops", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single report on the third run cycle.
    tick(1, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    tick(1, 4'b0010, 0);
    check("single_valid", 64'(rpt_valid), 64'd1);
    check("single_level", 64'(fifo_level), 64'd1);
    check("single_head_index", 64'(rpt_index), 64'd2);
    tick(1, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    rpt_ready = 1'b1;
    tick(0, 4'b0000, 0);
    check("single_drained", 64'(fifo_level), 64'd0);

    // Idle gating: reports with run low never queue and do not advance the index.
    do_reset();
    rpt_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick(0, 4'b1111, 0);
    check("idle_level", 64'(fifo_level), 64'd0);
    check("idle_valid", 64'(rpt_valid), 64'd0);
    tick(1, 4'b0001, 0);
    check("idle_next_index", 64'(rpt_index), 64'd0);
    tick(0, 4'b0000, 0);

    // Backpressure, overflow, then push and pop while full.
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 4'b0100, 0);
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_count), 64'd2);
    check("ovf_model_drops", 64'(drop_count), 64'(m_drops));
    check("ovf_head_index", 64'(rpt_index), 64'd0);
    rpt_ready = 1'b1;
    tick(1, 4'b0100, 0);
    check("full_pp_level", 64'(fifo_level), 64'd8);
    check("full_pp_drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) tick(0, 4'b0000, 0);
    check("ovf_drained", 64'(fifo_level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Clear during a push with three records queued.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 4'b0011, 0);
    check("pre_clear_level", 64'(fifo_level), 64'd3);
    tick(1, 4'b1000, 1);
    check("clear_level", 64'(fifo_level), 64'd0);
    check("clear_valid", 64'(rpt_valid), 64'd0);
    check("clear_overflow", 64'(overflow), 64'd0);
    tick(1, 4'b0001, 0);
    check("clear_next_index", 64'(rpt_index), 64'd0);
    rpt_ready = 1'b1;
    tick(0, 4'b0000, 0);

    // Asynchronous reset between edges.
    rpt_ready = 1'b0;
    tick(1, 4'b0110, 0);
    tick(1, 4'b0110, 0);
    check("pre_reset_level", 64'(fifo_level), 64'd2);
    #2;
    reset = 1'b0;
    exp_q.delete(); m_idx = 0; m_drops = 0;
    #1;
    check("async_valid", 64'(rpt_valid), 64'd0);
    check("async_level", 64'(fifo_level), 64'd0);
    check("async_mask", 64'(rpt_mask), 64'd0);
    check("async_index", 64'(rpt_index), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Index wrap on the narrow instance: 17th symbol gets index 0.
    for (int i = 0; i < 17; i++) begin
      run_w = 1'b1;
      report_w = (i == 16) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
    end
    run_w = 1'b0; report_w = '0;
    check("wrap_valid", 64'(valid_w), 64'd1);
    check("wrap_index", 64'(index_w), 64'd0);
    check("wrap_level", 64'(level_w), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
